// File: rtl/sobel_pkg.sv
// Shared types and sizing helpers for the Sobel streaming filter family.
package sobel_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACTIVE,
      DRAIN,
      DONE
   } sobel_state_e;

   localparam int DEF_PIXEL_WIDTH = 8;
   localparam int GRAD_EXTRA_BITS = 4;

   // 3x3 window, indexed [row][col] with row 0 on top and col 0 on the left.
   typedef logic [2:0][2:0][DEF_PIXEL_WIDTH-1:0] window_t;

   function automatic int grad_width(input int pixel_width);
      return pixel_width + GRAD_EXTRA_BITS;
   endfunction

   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sobel_kernel.sv
// Combinational Sobel kernel: 3x3 window in, saturated |gx|+|gy| and threshold compare out.
module sobel_kernel
   import sobel_pkg::*;
#(
   parameter int PIXEL_WIDTH = 8
) (
   input  logic [2:0][2:0][PIXEL_WIDTH-1:0] win_i,
   input  logic [PIXEL_WIDTH-1:0]           threshold_i,
   output logic [PIXEL_WIDTH-1:0]           mag_sat_o,
   output logic                             above_o
);

   localparam int GW = grad_width(PIXEL_WIDTH);

   logic signed [GW-1:0] gx;
   logic signed [GW-1:0] gy;
   logic signed [GW-1:0] abs_gx;
   logic signed [GW-1:0] abs_gy;
   logic        [GW-1:0] mag;

   function automatic logic signed [GW-1:0] ext(input logic [PIXEL_WIDTH-1:0] v);
      return $signed({{(GW-PIXEL_WIDTH){1'b0}}, v});
   endfunction

   assign gx = (ext(win_i[0][2]) + (ext(win_i[1][2]) <<< 1) + ext(win_i[2][2]))
             - (ext(win_i[0][0]) + (ext(win_i[1][0]) <<< 1) + ext(win_i[2][0]));
   assign gy = (ext(win_i[2][0]) + (ext(win_i[2][1]) <<< 1) + ext(win_i[2][2]))
             - (ext(win_i[0][0]) + (ext(win_i[0][1]) <<< 1) + ext(win_i[0][2]));

   assign abs_gx = gx[GW-1] ? -gx : gx;
   assign abs_gy = gy[GW-1] ? -gy : gy;
   // Each |g| is at most 4*(2^PW-1), so the sum always fits in GW bits.
   assign mag    = $unsigned(abs_gx) + $unsigned(abs_gy);

   assign mag_sat_o = (|mag[GW-1:PIXEL_WIDTH]) ? '1 : mag[PIXEL_WIDTH-1:0];
   assign above_o   = mag > GW'(threshold_i);

endmodule

// File: rtl/sobel_stream_filter.sv
// Streaming Sobel filter: two line buffers build a sliding 3x3 window, one output per interior pixel.
module sobel_stream_filter
   import sobel_pkg::*;
#(
   parameter int PIXEL_WIDTH = 8,
   parameter int IMG_W       = 32,
   parameter int IMG_H       = 32,
   parameter bit BINARY_MODE = 1'b0
) (
   input  logic                   clk_i,
   input  logic                   nreset_i,
   input  logic                   start_i,
   input  logic                   px_valid_i,
   input  logic [PIXEL_WIDTH-1:0] px_i,
   input  logic [PIXEL_WIDTH-1:0] threshold_i,
   output logic                   px_ready_o,
   output logic [PIXEL_WIDTH-1:0] px_o,
   output logic                   px_valid_o,
   output logic                   busy_o,
   output logic                   frame_done_o,
   output sobel_state_e           state_o
);

   localparam int COL_W = cnt_width(IMG_W);
   localparam int ROW_W = cnt_width(IMG_H);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

   sobel_state_e                     state;
   logic [COL_W-1:0]                 col;
   logic [ROW_W-1:0]                 row;
   logic [PIXEL_WIDTH-1:0]           lb0 [IMG_W];
   logic [PIXEL_WIDTH-1:0]           lb1 [IMG_W];
   logic [2:0][2:0][PIXEL_WIDTH-1:0] win;
   logic                             pend;
   logic                             accept;
   logic [PIXEL_WIDTH-1:0]           mag_sat;
   logic                             above;

   // Input handshake: a pixel transfers on a rising edge where px_valid_i and
   // px_ready_o are both high; px_valid_i may drop at any time without loss.
   assign px_ready_o = (state == ACTIVE);
   assign accept     = px_valid_i & px_ready_o;
   assign state_o    = state;

   sobel_kernel #(
      .PIXEL_WIDTH(PIXEL_WIDTH)
   ) u_kernel (
      .win_i      (win),
      .threshold_i(threshold_i),
      .mag_sat_o  (mag_sat),
      .above_o    (above)
   );

   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         state        <= IDLE;
         col          <= '0;
         row          <= '0;
         win          <= '0;
         pend         <= 1'b0;
         px_o         <= '0;
         px_valid_o   <= 1'b0;
         busy_o       <= 1'b0;
         frame_done_o <= 1'b0;
         for (int i = 0; i < IMG_W; i++) begin
            lb0[i] <= '0;
            lb1[i] <= '0;
         end
      end else begin
         px_valid_o   <= pend;
         pend         <= 1'b0;
         frame_done_o <= 1'b0;
         if (pend) begin
            px_o <= BINARY_MODE ? (above ? '1 : '0) : mag_sat;
         end

         if (accept) begin
            for (int r = 0; r < 3; r++) begin
               win[r][0] <= win[r][1];
               win[r][1] <= win[r][2];
            end
            win[0][2] <= lb1[col];
            win[1][2] <= lb0[col];
            win[2][2] <= px_i;
            lb1[col]  <= lb0[col];
            lb0[col]  <= px_i;
            // The window is complete once two full rows and two columns are behind it.
            pend      <= (row >= ROW_W'(2)) && (col >= COL_W'(2));
            if (col == COL_LAST) begin
               col <= '0;
               row <= row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end

         case (state)
            IDLE: begin
               if (start_i) begin
                  state  <= ACTIVE;
                  col    <= '0;
                  row    <= '0;
                  busy_o <= 1'b1;
               end
            end
            ACTIVE: begin
               if (accept && (col == COL_LAST) && (row == ROW_LAST)) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               // pend clear means the final result has already been registered.
               if (!pend) begin
                  state        <= DONE;
                  frame_done_o <= 1'b1;
               end
            end
            DONE: begin
               state  <= IDLE;
               busy_o <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sobel_stream_filter.sv
// Directed bench for sobel_stream_filter: three instances cover saturated 4x4, binary 4x4 and 5x4 frames.
module tb_sobel_stream_filter;
   import sobel_pkg::*;

   logic         clk = 1'b0;
   logic         nreset;
   logic         start [3];
   logic         valid [3];
   logic [7:0]   px    [3];
   logic [7:0]   thr;
   logic         ready [3];
   logic         pvo   [3];
   logic         busy  [3];
   logic         done  [3];
   logic [7:0]   pxo   [3];
   sobel_state_e st    [3];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int acc_cnt  [3];
   int last_acc [3];
   int done_cnt [3];
   int done_cyc [3];
   logic [7:0] got0[$];
   logic [7:0] got1[$];
   logic [7:0] got2[$];

   always #5 clk = ~clk;

   sobel_stream_filter #(.PIXEL_WIDTH(8), .IMG_W(4), .IMG_H(4), .BINARY_MODE(1'b0)) u_dut0 (
      .clk_i(clk), .nreset_i(nreset), .start_i(start[0]), .px_valid_i(valid[0]), .px_i(px[0]),
      .threshold_i(thr), .px_ready_o(ready[0]), .px_o(pxo[0]), .px_valid_o(pvo[0]),
      .busy_o(busy[0]), .frame_done_o(done[0]), .state_o(st[0]));

   sobel_stream_filter #(.PIXEL_WIDTH(8), .IMG_W(4), .IMG_H(4), .BINARY_MODE(1'b1)) u_dut1 (
      .clk_i(clk), .nreset_i(nreset), .start_i(start[1]), .px_valid_i(valid[1]), .px_i(px[1]),
      .threshold_i(thr), .px_ready_o(ready[1]), .px_o(pxo[1]), .px_valid_o(pvo[1]),
      .busy_o(busy[1]), .frame_done_o(done[1]), .state_o(st[1]));

   sobel_stream_filter #(.PIXEL_WIDTH(8), .IMG_W(5), .IMG_H(4), .BINARY_MODE(1'b0)) u_dut2 (
      .clk_i(clk), .nreset_i(nreset), .start_i(start[2]), .px_valid_i(valid[2]), .px_i(px[2]),
      .threshold_i(thr), .px_ready_o(ready[2]), .px_o(pxo[2]), .px_valid_o(pvo[2]),
      .busy_o(busy[2]), .frame_done_o(done[2]), .state_o(st[2]));

   always @(posedge clk) begin
      cyc = cyc + 1;
      for (int k = 0; k < 3; k++) begin
         if (valid[k] && ready[k]) begin
            acc_cnt[k]  = acc_cnt[k] + 1;
            last_acc[k] = cyc;
         end
      end
   end

   always @(negedge clk) begin
      if (pvo[0]) got0.push_back(pxo[0]);
      if (pvo[1]) got1.push_back(pxo[1]);
      if (pvo[2]) got2.push_back(pxo[2]);
      for (int k = 0; k < 3; k++) begin
         if (done[k]) begin
            done_cnt[k] = done_cnt[k] + 1;
            done_cyc[k] = cyc;
         end
      end
   end

   // kind 0: flat 100, 1: edge 0|255, 2: edge 0|10, other: x*x*3 + y*y*2 ramp
   function automatic logic [7:0] pix(input int kind, input int x, input int y);
      case (kind)
         0:       return 8'd100;
         1:       return (x >= 2) ? 8'd255 : 8'd0;
         2:       return (x >= 2) ? 8'd10 : 8'd0;
         default: return 8'(x * x * 3 + y * y * 2);
      endcase
   endfunction

   function automatic logic [7:0] model_px(input int kind, input int cx, input int cy);
      int p [3][3];
      int gx;
      int gy;
      int mag;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            p[r][c] = int'(pix(kind, cx - 1 + c, cy - 1 + r));
      gx  = (p[0][2] + 2 * p[1][2] + p[2][2]) - (p[0][0] + 2 * p[1][0] + p[2][0]);
      gy  = (p[2][0] + 2 * p[2][1] + p[2][2]) - (p[0][0] + 2 * p[0][1] + p[0][2]);
      mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      return (mag > 255) ? 8'd255 : 8'(mag);
   endfunction

   task automatic run_frame(input int d, input int w, input int h, input int kind, input int max_gap);
      int d0;
      d0 = done_cnt[d];
      @(negedge clk);
      start[d] = 1'b1;
      @(negedge clk);
      start[d] = 1'b0;
      for (int y = 0; y < h; y++) begin
         for (int x = 0; x < w; x++) begin
            valid[d] = 1'b0;
            repeat ($urandom_range(0, max_gap)) @(negedge clk);
            valid[d] = 1'b1;
            px[d]    = pix(kind, x, y);
            @(negedge clk);
         end
      end
      valid[d] = 1'b0;
      for (int i = 0; i < 40 && done_cnt[d] == d0; i++) @(negedge clk);
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      nreset = 1'b0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if ({ready[k], pvo[k], busy[k], done[k], pxo[k]} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs dut%0d: got %03h expected 000", k,
                     {ready[k], pvo[k], busy[k], done[k], pxo[k]});
         end
         checks++;
         if (st[k] !== IDLE) begin
            errors++;
            $display("FAIL reset_state dut%0d: got %0d expected %0d", k, int'(st[k]), int'(IDLE));
         end
      end
      nreset = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_flat();
      int a0;
      int d0;
      a0 = acc_cnt[0];
      d0 = done_cnt[0];
      got0.delete();
      run_frame(0, 4, 4, 0, 0);
      checks++;
      if (got0.size() != 4) begin
         errors++;
         $display("FAIL flat_count: got %0d expected 4", got0.size());
      end
      foreach (got0[i]) begin
         checks++;
         if (got0[i] !== 8'd0) begin
            errors++;
            $display("FAIL flat_value[%0d]: got %0d expected 0", i, got0[i]);
         end
      end
      checks++;
      if (acc_cnt[0] - a0 != 16) begin
         errors++;
         $display("FAIL flat_accepts: got %0d expected 16", acc_cnt[0] - a0);
      end
      checks++;
      if (done_cnt[0] - d0 != 1) begin
         errors++;
         $display("FAIL flat_done_count: got %0d expected 1", done_cnt[0] - d0);
      end
      checks++;
      if (done_cyc[0] - last_acc[0] != 2) begin
         errors++;
         $display("FAIL flat_done_latency: got %0d expected 2", done_cyc[0] - last_acc[0]);
      end
      checks++;
      if (busy[0] !== 1'b0 || st[0] !== IDLE) begin
         errors++;
         $display("FAIL flat_idle_after: got busy=%0b state=%0d expected busy=0 state=0",
                  busy[0], int'(st[0]));
      end
   endtask

   task automatic test_vertical_edge();
      got0.delete();
      run_frame(0, 4, 4, 1, 0);
      checks++;
      if (got0.size() != 4) begin
         errors++;
         $display("FAIL edge_count: got %0d expected 4", got0.size());
      end
      foreach (got0[i]) begin
         checks++;
         if (got0[i] !== 8'd255) begin
            errors++;
            $display("FAIL edge_value[%0d]: got %0d expected 255", i, got0[i]);
         end
      end
   endtask

   task automatic test_threshold();
      logic [7:0] exp_q[$];
      for (int pass = 0; pass < 2; pass++) begin
         thr = (pass == 0) ? 8'd39 : 8'd40;
         exp_q.delete();
         repeat (4) exp_q.push_back((pass == 0) ? 8'd255 : 8'd0);
         got1.delete();
         run_frame(1, 4, 4, 2, 0);
         checks++;
         if (got1.size() != exp_q.size()) begin
            errors++;
            $display("FAIL thresh_count thr=%0d: got %0d expected %0d", thr, got1.size(), exp_q.size());
         end
         foreach (got1[i]) begin
            checks++;
            if (i >= exp_q.size() || got1[i] !== exp_q[i]) begin
               errors++;
               $display("FAIL thresh_value thr=%0d [%0d]: got %0d expected %0d", thr, i, got1[i],
                        (i < exp_q.size()) ? exp_q[i] : 8'd0);
            end
         end
      end
   endtask

   task automatic test_stalls();
      logic [7:0] exp_q[$];
      int d0;
      d0 = done_cnt[2];
      for (int y = 1; y <= 2; y++)
         for (int x = 1; x <= 3; x++)
            exp_q.push_back(model_px(3, x, y));
      got2.delete();
      run_frame(2, 5, 4, 3, 3);
      checks++;
      if (got2.size() != 6) begin
         errors++;
         $display("FAIL stall_count: got %0d expected 6", got2.size());
      end
      foreach (got2[i]) begin
         checks++;
         if (i >= exp_q.size() || got2[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL stall_value[%0d]: got %0d expected %0d", i, got2[i],
                     (i < exp_q.size()) ? exp_q[i] : 8'd0);
         end
      end
      checks++;
      if (done_cnt[2] - d0 != 1) begin
         errors++;
         $display("FAIL stall_done_count: got %0d expected 1", done_cnt[2] - d0);
      end
   endtask

   task automatic test_protocol();
      int a0;
      int d0;
      int n;
      a0 = acc_cnt[0];
      d0 = done_cnt[0];
      @(negedge clk);
      valid[0] = 1'b1;
      px[0]    = 8'd77;
      repeat (3) @(negedge clk);
      checks++;
      if (ready[0] !== 1'b0 || acc_cnt[0] != a0 || st[0] !== IDLE) begin
         errors++;
         $display("FAIL idle_valid: got ready=%0b accepts=%0d state=%0d expected 0 0 0",
                  ready[0], acc_cnt[0] - a0, int'(st[0]));
      end
      valid[0] = 1'b0;
      got0.delete();
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      n = 0;
      for (int y = 0; y < 4; y++) begin
         for (int x = 0; x < 4; x++) begin
            if (n == 6) begin
               valid[0] = 1'b0;
               start[0] = 1'b1;
               @(negedge clk);
               start[0] = 1'b0;
               checks++;
               if (st[0] !== ACTIVE || busy[0] !== 1'b1 || acc_cnt[0] - a0 != 6) begin
                  errors++;
                  $display("FAIL start_in_active: got state=%0d busy=%0b accepts=%0d expected 1 1 6",
                           int'(st[0]), busy[0], acc_cnt[0] - a0);
               end
            end
            valid[0] = 1'b1;
            px[0]    = pix(1, x, y);
            @(negedge clk);
            n++;
         end
      end
      valid[0] = 1'b0;
      for (int i = 0; i < 40 && done_cnt[0] == d0; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      checks++;
      if (got0.size() != 4 || acc_cnt[0] - a0 != 16 || done_cnt[0] - d0 != 1) begin
         errors++;
         $display("FAIL protocol_frame: got outputs=%0d accepts=%0d done=%0d expected 4 16 1",
                  got0.size(), acc_cnt[0] - a0, done_cnt[0] - d0);
      end
      foreach (got0[i]) begin
         checks++;
         if (got0[i] !== 8'd255) begin
            errors++;
            $display("FAIL protocol_value[%0d]: got %0d expected 255", i, got0[i]);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      int d0;
      got0.delete();
      @(negedge clk);
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      for (int i = 0; i < 7; i++) begin
         valid[0] = 1'b1;
         px[0]    = pix(1, i % 4, i / 4);
         @(negedge clk);
      end
      valid[0] = 1'b0;
      nreset   = 1'b0;
      #1;
      checks++;
      if ({ready[0], pvo[0], busy[0], done[0], pxo[0]} !== 12'h000 || st[0] !== IDLE) begin
         errors++;
         $display("FAIL midreset_outputs: got %03h state=%0d expected 000 state=0",
                  {ready[0], pvo[0], busy[0], done[0], pxo[0]}, int'(st[0]));
      end
      repeat (2) @(negedge clk);
      nreset = 1'b1;
      repeat (4) @(negedge clk);
      checks++;
      if (got0.size() != 0) begin
         errors++;
         $display("FAIL midreset_no_output: got %0d outputs expected 0", got0.size());
      end
      d0 = done_cnt[0];
      run_frame(0, 4, 4, 0, 0);
      checks++;
      if (got0.size() != 4 || done_cnt[0] - d0 != 1 || done_cyc[0] - last_acc[0] != 2) begin
         errors++;
         $display("FAIL midreset_refill: got outputs=%0d done=%0d latency=%0d expected 4 1 2",
                  got0.size(), done_cnt[0] - d0, done_cyc[0] - last_acc[0]);
      end
      foreach (got0[i]) begin
         checks++;
         if (got0[i] !== 8'd0) begin
            errors++;
            $display("FAIL midreset_value[%0d]: got %0d expected 0", i, got0[i]);
         end
      end
   endtask

   initial begin
      nreset = 1'b0;
      thr    = 8'd0;
      for (int k = 0; k < 3; k++) begin
         start[k] = 1'b0;
         valid[k] = 1'b0;
         px[k]    = 8'd0;
      end
      test_reset();
      test_flat();
      test_vertical_edge();
      test_threshold();
      test_stalls();
      test_protocol();
      test_reset_mid_frame();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached before summary");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/sobel_stream_filter.md
# sobel_stream_filter

Parametrised streaming Sobel edge filter. It accepts a raster-scan grayscale frame one pixel per handshake and keeps two internal line buffers, so each input pixel is sent exactly once rather than re-sent as 9- or 3-pixel bursts. It emits the gradient magnitude for every interior pixel, either saturated or thresholded to binary. It sits between the grayscale converter and the output packer.

## Interface
- PIXEL_WIDTH, 8, bits per input and output pixel
- IMG_W, 32, frame width in pixels (≥3)
- IMG_H, 32, frame height in pixels (≥3)
- BINARY_MODE, 0, 0 = saturated magnitude out; 1 = thresholded out (all-ones / zero)
- clk_i  in  1  clock
- nreset_i  in  1  reset: asynchronous, active-low
- start_i  in  1  begins a frame; sampled only in IDLE
- px_valid_i  in  1  input pixel valid
- px_i  in  PIXEL_WIDTH  input pixel, raster order
- threshold_i  in  PIXEL_WIDTH  binary-mode threshold; must be stable during a frame
- px_ready_o  out  1  block accepts px_i this cycle
- px_o  out  PIXEL_WIDTH  filtered pixel
- px_valid_o  out  1  px_o valid, one-cycle pulse per output
- busy_o  out  1  high from start accepted until frame_done_o
- frame_done_o  out  1  one-cycle pulse after the last output

## Operation
- Reset: state IDLE; counters, line buffers and window cleared; all outputs 0.
- **IDLE**
  - px_ready_o = 0.
  - start_i = 1 → ACTIVE; col and row are cleared.
- **ACTIVE**
  - px_ready_o = 1. A pixel is accepted when px_valid_i & px_ready_o.
  - On accept:
    - The window shifts left one column.
    - The new right column is {line buffer 1 at col, line buffer 0 at col, px_i}, top to bottom.
    - Line buffer 1 at col takes line buffer 0 at col; line buffer 0 at col takes px_i.
    - col increments. At col = IMG_W-1 it wraps to 0 and row increments.
  - Accept at position (row ≥2, col ≥2) → window is complete; mark output pending for the window centred at (row-1, col-1).
  - Accept of the final pixel (IMG_H-1, IMG_W-1) → DRAIN.
- **DRAIN**
  - px_ready_o = 0.
  - Wait for the last pending output, then → DONE.
- **DONE**
  - frame_done_o = 1 for one cycle, then → IDLE.
- start_i outside IDLE is ignored.
- Gaps in px_valid_i stall the pipeline without loss.
- Exactly (IMG_W-2)·(IMG_H-2) outputs per frame. Border pixels produce no output.
- Arithmetic:
  - gx = (p02 + 2·p12 + p22) − (p00 + 2·p10 + p20)
  - gy = (p20 + 2·p21 + p22) − (p00 + 2·p01 + p02)
  - gx and gy are signed, PIXEL_WIDTH+4 bits.
  - mag = |gx| + |gy|, unsigned, PIXEL_WIDTH+4 bits; no overflow is possible.
  - BINARY_MODE = 0: px_o = min(mag, 2^PIXEL_WIDTH−1).
  - BINARY_MODE = 1: px_o = all-ones if mag > threshold_i, else 0. Compare is strict.
- Reset mid-frame: immediate return to IDLE with all outputs 0. A pending output is discarded.

## Timing
- Accept on edge N updates the window.
- px_o and px_valid_o are registered on edge N+1 and stay valid for one cycle.
- Latency is 2 edges from sampled input to visible output.
- Throughput: one output per clock when px_valid_i is held high.
- frame_done_o rises on the edge after the last px_valid_o falls, i.e. the DONE cycle.
- busy_o falls with the IDLE entry.
- px_o holds its last value when px_valid_o = 0.

## Structure
- Shared package sobel_pkg holds:
  - the window typedef (3×3 of PIXEL_WIDTH) and the state enum {IDLE, ACTIVE, DRAIN, DONE};
  - the gradient-width constant PIXEL_WIDTH+4 and the counter-width function clog2(IMG_W) / clog2(IMG_H).
- Sub-module sobel_kernel: combinational, window in → saturated magnitude and threshold compare out. Reused by future multi-lane variants.
- Line buffers are register arrays (IMG_W × PIXEL_WIDTH × 2), not macros, at these sizes.

## Test plan
- **Flat image:** 4×4, all pixels = 100, continuous valid → 4 outputs, each 0; frame_done_o once, 2 cycles after the last accept.
- **Vertical edge:** 4×4, cols 0–1 = 0, cols 2–3 = 255, BINARY_MODE = 0 → 4 outputs, each 255 (gx = 1020, saturated).
- **Threshold boundary:** BINARY_MODE = 1, 4×4, cols 0–1 = 0, cols 2–3 = 10 → gx = 40 at every output; threshold_i = 39 → all 255; threshold_i = 40 → all 0.
- **Backpressure-free stalls:** 5×4 ramp image with random 0–3-cycle gaps in px_valid_i → exactly 6 outputs, values match a software model, no extra px_valid_o.
- **Reset mid-frame:** nreset_i low after 7 accepts → all outputs 0 immediately, no output in flight; a following full 4×4 flat frame yields 4 zeros and a correct frame_done_o.
- **Protocol:** start_i pulsed during ACTIVE → ignored, counts unchanged; px_valid_i in IDLE → px_ready_o = 0, nothing accepted.
